// File: rtl/serial_byte_rx.sv
// Serial byte receiver: 8E1 frames (start, 8 data LSB first, even parity, stop),
// writing each good byte to a downstream register via dout/wr_en.
module serial_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       wr_en,
  output logic       par_err,
  output logic       frm_err,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             par_bad, par_bad_n;
  logic [7:0]       dout_n;
  logic             wr_en_n, par_err_n, frm_err_n, busy_n;
  logic             sync1, rxs;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      dout    <= 8'h00;
      wr_en   <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par_bad <= par_bad_n;
      dout    <= dout_n;
      wr_en   <= wr_en_n;
      par_err <= par_err_n;
      frm_err <= frm_err_n;
      busy    <= busy_n;
    end
  end

  // Counter restarts from zero whenever a bit period completes or a state is entered
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    idx_n     = idx;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    dout_n    = dout;
    wr_en_n   = 1'b0;
    par_err_n = 1'b0;
    frm_err_n = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n          = '0;
          shreg_n[idx]   = rxs;
          idx_n          = idx + 3'd1;
          if (idx == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (cnt == FULL_LAST) begin
          cnt_n     = '0;
          par_bad_n = (^shreg) ^ rxs;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n = '0;
          if (!rxs) begin
            frm_err_n = 1'b1;
            state_n   = WAIT_IDLE;
          end else if (par_bad) begin
            par_err_n = 1'b1;
            state_n   = IDLE;
          end else begin
            dout_n  = shreg;
            wr_en_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Scoreboard bench for serial_byte_rx: frames push expected events, a monitor
// collects observed strobes, and each test compares the two queues.
module tb_serial_byte_rx;

  localparam int unsigned CPB = 4;

  typedef struct packed {
    logic [1:0] kind;   // 1 = wr_en, 2 = par_err, 3 = frm_err
    logic [7:0] data;   // dout at the strobe
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] dout;
  logic       wr_en, par_err, frm_err, busy;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         viol = 0;
  logic [7:0] model_dout = 8'h00;
  logic [7:0] prev_dout = 8'h00;

  serial_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .dout    (dout),
    .wr_en   (wr_en),
    .par_err (par_err),
    .frm_err (frm_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Collect strobes; flag overlapping strobes and dout changes without wr_en
  always @(negedge clk) begin
    if (reset) begin
      prev_dout <= dout;
    end else begin
      if (int'(wr_en) + int'(par_err) + int'(frm_err) > 1) viol++;
      if (dout !== prev_dout && wr_en !== 1'b1) viol++;
      prev_dout <= dout;
      if (wr_en)        obs_q.push_back('{kind: 2'd1, data: dout});
      else if (par_err) obs_q.push_back('{kind: 2'd2, data: dout});
      else if (frm_err) obs_q.push_back('{kind: 2'd3, data: dout});
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
    logic [10:0] bits;
    bits = {stop_bit, (^d) ^ par_flip, d, 1'b0};
    if (!stop_bit) exp_q.push_back('{kind: 2'd3, data: model_dout});
    else if (par_flip) exp_q.push_back('{kind: 2'd2, data: model_dout});
    else begin
      model_dout = d;
      exp_q.push_back('{kind: 2'd1, data: d});
    end
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dout, wr_en, par_err, frm_err, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_values: got dout=%h wr=%b par=%b frm=%b busy=%b, want all zero",
               dout, wr_en, par_err, frm_err, busy);
    end
    reset = 1'b0;
    settle();
    vectors++;
    if (busy !== 1'b0 || obs_q.size() !== 0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b events=%0d, want busy=0 events=0", busy, obs_q.size());
    end
  endtask

  task automatic test_good_frame();
    ev_t e, o;
    send_frame(8'hA5, 1'b0, 1'b1);
    settle();
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL good_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL good_event: got kind=%0d dout=%h, want kind=%0d dout=%h", o.kind, o.data, e.kind, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_parity_error();
    ev_t e, o;
    send_frame(8'h01, 1'b1, 1'b1);
    settle();
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL parity_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL parity_event: got kind=%0d dout=%h, want kind=%0d dout=%h", o.kind, o.data, e.kind, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
    vectors++;
    if (dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL parity_hold: got dout=%h, want a5", dout);
    end
  endtask

  task automatic test_break();
    ev_t e, o;
    int  busy_low;
    busy_low = 0;
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
    end
    vectors++;
    if (busy_low !== 0) begin
      miscompares++;
      $display("FAIL break_busy: got busy low in %0d cycles, want 0", busy_low);
    end
    rx = 1'b1;
    settle();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL break_release: got busy=%b, want 0", busy);
    end
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL break_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL break_event: got kind=%0d dout=%h, want kind=%0d dout=%h", o.kind, o.data, e.kind, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    settle();
    vectors++;
    if (busy !== 1'b0 || obs_q.size() !== 0 || dout !== model_dout) begin
      miscompares++;
      $display("FAIL glitch: got busy=%b events=%0d dout=%h, want busy=0 events=0 dout=%h",
               busy, obs_q.size(), dout, model_dout);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    ev_t e, o;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + 2) @(negedge clk);
    reset = 1'b1;
    model_dout = 8'h00;
    #1;
    vectors++;
    if ({dout, wr_en, par_err, frm_err, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL midreset_values: got dout=%h wr=%b par=%b frm=%b busy=%b, want all zero",
               dout, wr_en, par_err, frm_err, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    settle();
    vectors++;
    if (obs_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got events=%0d busy=%b, want events=0 busy=0", obs_q.size(), busy);
    end
    obs_q.delete();
    send_frame(8'h5A, 1'b0, 1'b1);
    settle();
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL midreset_event: got kind=%0d dout=%h, want kind=%0d dout=%h", o.kind, o.data, e.kind, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1);
    settle();
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL b2b_event: got kind=%0d dout=%h, want kind=%0d dout=%h", o.kind, o.data, e.kind, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_protocol();
    vectors++;
    if (viol !== 0) begin
      miscompares++;
      $display("FAIL protocol: got %0d overlapping-strobe or stray-dout cycles, want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_break();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
